stream_switch: RTL and testbench
================================

# stream_switch

Upstream neighbour of the compute tiles. It accepts a valid/ready byte stream tagged with a destination tile and drives each of four tile input ports. It snoops configuration bytes to mirror every tile's chaining setup, captures tile results, and re-injects each result into the next tile when chaining is configured. Results with no next hop are queued to a valid/ready output stream.

## Interface
- `FIFO_DEPTH`, default 4: output queue depth. It also sets the credit limit.
- `MAX_HOPS`, default 3: maximum number of chained forwards per operand.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, 8: tile byte. Class is bits [7:6]: 00 = weight, 01 = config, 1x = data.
- `in_dest`, input, 2: destination tile index.
- `in_valid`, input, 1: upstream byte valid.
- `in_ready`, output, 1: byte accepted on an edge where `in_valid & in_ready`.
- `tile_data_out`, output, 32: byte i at [8i+7:8i] drives tile i `switch_data_in`.
- `tile_data_in`, input, 32: byte i is tile i `switch_data_out`.
- `out_data`, output, 8: final result byte.
- `out_tile`, output, 2: index of the tile that produced `out_data`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts on an edge where `out_valid & out_ready`.

## Operation
**Tile port registers**
- Four 8-bit port registers, each reset to 8'h00. 8'h00 is a weight-0 load, which matches tile reset state.
- Each register holds its last byte until it is written again.
- All tile encodings are idempotent under hold, so no idle code exists and none is needed.

**Issuing a byte** (one byte per edge at most):
- A chained forward has priority.
- Otherwise an accepted input byte is written to port `in_dest`.

**Chain mirror**, per tile:
- Fields are `has_next` (reset 0) and `next` (reset 0).
- A config byte (class 01) issued to tile i sets `has_next[i] = 1` and `next[i] = in_data[5:4]`.
- Only reset clears `has_next`.

**Pending pipeline**
- Two stages, S1 then S2, each holding {valid, tile[1:0], hops[1:0]}.
- A data-class issue loads S1 with hops 0 for input bytes, or hops+1 for forwards.
- Each edge shifts S1 into S2.

**S2 valid, tile t**
- At that edge the switch samples `tile_data_in[t]` as r.
- If `has_next[t]` and hops < `MAX_HOPS`:
  - Write {2'b10, r[5:0]} to port `next[t]`.
  - S1 takes {1, next[t], hops+1}.
- Otherwise push {r, t} into the output FIFO.

**Flow control**
- `in_ready = !(S2.valid & fwd_cond) & (fifo_count + S1.valid + S2.valid < FIFO_DEPTH)`.
- This is combinational from registers only, with no path from `in_valid`.
- The FIFO therefore never overflows, and a push on a full FIFO is a design error.

**Output FIFO**
- In-order.
- Simultaneous push and pop are allowed, and count is unchanged.
- `out_valid = count != 0`. `out_data`/`out_tile` show the head entry.

## Timing
- Reset values:
  - `tile_data_out` = 0.
  - S1/S2 invalid.
  - FIFO empty, `out_valid` = 0.
  - `in_ready` = 1.
  - Chain mirror cleared.
- Reset mid-operation drops all pending and queued results immediately.
- Latency:
  - Data accepted at edge E0 appears on the tile port after E0.
  - The tile registers it at E1.
  - The switch samples at E2, and `out_valid` is high in the cycle after E2.
  - Each chained hop adds 2 cycles.
- During any cycle where S2 forwards, `in_ready` = 0 and the input stays stalled.
- Weight and config bytes take no pipeline slot and complete on the port after one edge.
- A self-loop (`next[t] == t`) is legal and terminates after `MAX_HOPS` forwards.

## Structure
- Shared package `core_pkg`:
  - Class encodings `CLS_WEIGHT` = 2'b00, `CLS_CONFIG` = 2'b01, data prefix 2'b10.
  - Pending-entry struct.
  - `FIFO_DEPTH`, `MAX_HOPS` defaults.
- Sub-module `result_fifo`: synchronous FIFO of {data[7:0], tile[1:0]} with a count output.

## Test plan
- Reset with `in_valid` = 0 gives `tile_data_out` = 0, `out_valid` = 0, `in_ready` = 1.
- 0x05 to tile 1, then 0x83 to tile 1 (tile model add) gives `out_data` = 0x08, `out_tile` = 1, valid 2 cycles after acceptance.
- Chain with add on every tile:
  - Stimulus: 0x50 to tile 0, 0x02 to tile 0, 0x03 to tile 1, then 0x81 to tile 0.
  - Tile 1 port sees 0x83.
  - `in_ready` is low for one cycle.
  - Output 0x06 from tile 1, 4 cycles after acceptance.
- Self-loop:
  - Stimulus: 0x60 to tile 2, 0x01 to tile 2, then 0x80 to tile 2.
  - Port sequence is 0x81, 0x82, 0x83.
  - Output 0x04 from tile 2.
- Backpressure:
  - With `out_ready` = 0, send data bytes to tiles 0–3.
  - `in_ready` drops after the 4th acceptance and stays low.
  - Raising `out_ready` drains 4 results in issue order.
- Assert `rst_n` while a chain is in flight: no `out_valid` follows, and all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings and record types for the stream switch and its result queue.
package core_pkg;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_HOPS   = 3;

  localparam logic [1:0] CLS_WEIGHT = 2'b00;
  localparam logic [1:0] CLS_CONFIG = 2'b01;
  localparam logic [1:0] CLS_DATA   = 2'b10;

  // One in-flight operand waiting on a tile result.
  typedef struct packed {
    logic       vld;
    logic [1:0] tile;
    logic [1:0] hops;
  } pend_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] tile;
  } res_t;
endpackage

// File: rtl/result_fifo.sv
// In-order result queue; push and pop may coincide, count is exposed for credit.
module result_fifo import core_pkg::*; #(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  res_t          push_data_i,
  input  logic          pop_i,
  output res_t          head_o,
  output logic [CW-1:0] count_o
);
  res_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop     = pop_i & (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop)    rd_q <= inc(rd_q);
      case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/stream_switch.sv
// Drives four tile ports from a tagged byte stream, mirrors tile chaining config,
// re-injects chained results and queues terminal results downstream.
module stream_switch import core_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_HOPS   = DEF_MAX_HOPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic [1:0]  in_dest,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] tile_data_out,
  input  logic [31:0] tile_data_in,
  output logic [7:0]  out_data,
  output logic [1:0]  out_tile,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [3:0][7:0] port_q, port_d;
  logic [3:0]      has_next_q, has_next_d;
  logic [3:0][1:0] next_q, next_d;
  pend_t           s1_q, s1_d, s2_q;
  logic [3:0][7:0] tdi;
  logic [7:0]      r;
  logic            fwd, accept, push;
  logic [CW-1:0]   fifo_cnt;
  res_t            head;

  assign tdi = tile_data_in;
  assign r   = tdi[s2_q.tile];
  assign fwd = s2_q.vld & has_next_q[s2_q.tile] & (int'(s2_q.hops) < MAX_HOPS);

  // Credit counts every operand still able to land in the queue.
  assign in_ready = !fwd &
                    ((int'(fifo_cnt) + int'(s1_q.vld) + int'(s2_q.vld)) < FIFO_DEPTH);
  assign accept   = in_valid & in_ready;
  assign push     = s2_q.vld & !fwd;

  always_comb begin
    port_d     = port_q;
    has_next_d = has_next_q;
    next_d     = next_q;
    s1_d       = '0;
    if (fwd) begin
      port_d[next_q[s2_q.tile]] = {CLS_DATA, r[5:0]};
      s1_d = '{vld: 1'b1, tile: next_q[s2_q.tile], hops: s2_q.hops + 2'd1};
    end else if (accept) begin
      port_d[in_dest] = in_data;
      if (in_data[7]) s1_d = '{vld: 1'b1, tile: in_dest, hops: 2'd0};
      if (in_data[7:6] == CLS_CONFIG) begin
        has_next_d[in_dest] = 1'b1;
        next_d[in_dest]     = in_data[5:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q     <= '0;
      has_next_q <= '0;
      next_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      port_q     <= port_d;
      has_next_q <= has_next_d;
      next_q     <= next_d;
      s1_q       <= s1_d;
      s2_q       <= s1_q;
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i('{data: r, tile: s2_q.tile}),
    .pop_i      (out_ready),
    .head_o     (head),
    .count_o    (fifo_cnt)
  );

  assign tile_data_out = port_q;
  assign out_valid     = (fifo_cnt != '0);
  assign out_data      = head.data;
  assign out_tile      = head.tile;
endmodule

// File: tb/tb_stream_switch.sv
// Bench for stream_switch with a behavioural add-tile model on every port.
module tb_stream_switch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_dest = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] tile_data_out, tile_data_in;
  logic [7:0]  out_data;
  logic [1:0]  out_tile;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_switch dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .tile_data_out(tile_data_out),
    .tile_data_in(tile_data_in), .out_data(out_data), .out_tile(out_tile),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Tile model: weight byte loads w, data byte registers w + operand.
  logic [3:0][5:0] w_q;
  logic [3:0][7:0] tres_q;
  logic [3:0][7:0] tport;
  assign tport        = tile_data_out;
  assign tile_data_in = tres_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      tres_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (tport[i][7:6] == 2'b00) w_q[i] <= tport[i][5:0];
        if (tport[i][7]) tres_q[i] <= {2'b00, w_q[i]} + {2'b00, tport[i][5:0]};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns 1ns after the edge that accepted it.
  task automatic send(input logic [1:0] dest, input logic [7:0] data);
    int waited = 0;
    in_dest  = dest;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0] dest;
    logic [7:0] wb;
    logic [7:0] db;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [7:0] exp_bp[4];
    int seen;
    vecs[0] = '{dest: 2'd1, wb: 8'h05, db: 8'h83, exp: 8'h08};
    vecs[1] = '{dest: 2'd0, wb: 8'h00, db: 8'h80, exp: 8'h00};
    vecs[2] = '{dest: 2'd3, wb: 8'h3F, db: 8'hBF, exp: 8'h7E};
    vecs[3] = '{dest: 2'd2, wb: 8'h10, db: 8'hA5, exp: 8'h35};
    exp_bp  = '{8'h01, 8'h02, 8'h03, 8'h04};

    // Reset values, sampled while reset is held.
    #12;
    chk("rst_tile_data_out", tile_data_out, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single-tile add vectors: result valid exactly two edges after acceptance.
    foreach (vecs[k]) begin
      send(vecs[k].dest, vecs[k].wb);
      send(vecs[k].dest, vecs[k].db);
      chk($sformatf("vec%0d_port", k), {24'b0, tport[vecs[k].dest]}, {24'b0, vecs[k].db});
      tick();
      chk($sformatf("vec%0d_early", k), {31'b0, out_valid}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", k), {24'b0, out_data}, {24'b0, vecs[k].exp});
      chk($sformatf("vec%0d_tile", k), {30'b0, out_tile}, {30'b0, vecs[k].dest});
      pop_one();
      chk($sformatf("vec%0d_drained", k), {31'b0, out_valid}, 32'd0);
    end

    // Chain tile 0 -> tile 1.
    do_reset();
    send(2'd0, 8'h50);
    send(2'd0, 8'h02);
    send(2'd1, 8'h03);
    send(2'd0, 8'h81);
    chk("chain_rdy_e0", {31'b0, in_ready}, 32'd1);
    tick();
    chk("chain_rdy_e1", {31'b0, in_ready}, 32'd0);
    tick();
    chk("chain_rdy_e2", {31'b0, in_ready}, 32'd1);
    chk("chain_port1", {24'b0, tport[1]}, 32'h83);
    tick();
    chk("chain_early", {31'b0, out_valid}, 32'd0);
    chk("chain_rdy_e3", {31'b0, in_ready}, 32'd1);
    tick();
    chk("chain_valid", {31'b0, out_valid}, 32'd1);
    chk("chain_data", {24'b0, out_data}, 32'h06);
    chk("chain_tile", {30'b0, out_tile}, 32'd1);
    pop_one();

    // Self-loop on tile 2 runs exactly three forwards.
    do_reset();
    send(2'd2, 8'h60);
    send(2'd2, 8'h01);
    send(2'd2, 8'h80);
    tick(); tick();
    chk("loop_hop1", {24'b0, tport[2]}, 32'h81);
    tick(); tick();
    chk("loop_hop2", {24'b0, tport[2]}, 32'h82);
    tick(); tick();
    chk("loop_hop3", {24'b0, tport[2]}, 32'h83);
    tick();
    chk("loop_early", {31'b0, out_valid}, 32'd0);
    tick();
    chk("loop_valid", {31'b0, out_valid}, 32'd1);
    chk("loop_data", {24'b0, out_data}, 32'h04);
    chk("loop_tile", {30'b0, out_tile}, 32'd2);
    pop_one();

    // Backpressure: four accepts fill the credit window.
    do_reset();
    for (int i = 0; i < 4; i++) send(2'(i), 8'h81 + 8'(i));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) seen++;
      tick();
    end
    chk("bp_ready_low", 32'(seen), 32'd0);
    chk("bp_full_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_data%0d", i), {24'b0, out_data}, {24'b0, exp_bp[i]});
      chk($sformatf("bp_tile%0d", i), {30'b0, out_tile}, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("bp_empty", {31'b0, out_valid}, 32'd0);
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);

    // Reset lands while a self-loop is in flight.
    do_reset();
    send(2'd2, 8'h60);
    send(2'd2, 8'h01);
    send(2'd2, 8'h80);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_port", tile_data_out, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    chk("midrst_port_idle", tile_data_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
